// File: rtl/operand_shift_loader.sv
// operand_shift_loader
//   Serial-to-parallel operand loader. Each of NUM_SRC channels shifts one bit
//   per enabled cycle into a SRC_WIDTH-bit register. After SRC_WIDTH shifts the
//   frame is held on ops_out_o with a valid/ready handshake until accepted.
//
//   Optional feature (macro OPERAND_SHIFT_LOADER_READBACK_EN): on each accept
//   the compressor result dst_in_i is captured and then returned MSB first on
//   dst_serial_o, one bit per shift_en_i cycle. Without the macro dst_in_i is
//   unused and dst_serial_o is tied 0.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   shift_en_i   shift one bit into every channel
//   src_in_i     serial input bit per channel
//   ops_out_o    flattened operand bus, channel i at [i*SRC_WIDTH +: SRC_WIDTH]
//   ops_valid_o  complete frame present
//   ops_ready_i  consumer accepts frame when high with ops_valid_o
//   bit_cnt_o    bits shifted into the current frame
//   overrun_o    sticky: shift requested while a frame was held
//   dst_in_i     compressor result (readback only)
//   dst_serial_o serial result bit (readback only, else 0)
module operand_shift_loader #(
    parameter int unsigned NUM_SRC   = 30,
    parameter int unsigned SRC_WIDTH = 30,
    parameter int unsigned DST_WIDTH = 36,
    localparam int unsigned CNT_WIDTH = $clog2(SRC_WIDTH + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           shift_en_i,
    input  logic [NUM_SRC-1:0]             src_in_i,
    output logic [NUM_SRC*SRC_WIDTH-1:0]   ops_out_o,
    output logic                           ops_valid_o,
    input  logic                           ops_ready_i,
    output logic [CNT_WIDTH-1:0]           bit_cnt_o,
    output logic                           overrun_o,
    input  logic [DST_WIDTH-1:0]           dst_in_i,
    output logic                           dst_serial_o
);

    typedef enum logic [0:0] {StLoad, StFull} state_e;

    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(SRC_WIDTH - 1);

    state_e                         state_q;
    logic [NUM_SRC*SRC_WIDTH-1:0]   ops_q;
    logic [CNT_WIDTH-1:0]           bit_cnt_q;
    logic                           valid_q;
    logic                           overrun_q;

    logic accept;
    logic take_shift;

    assign accept     = valid_q & ops_ready_i;
    // A shift in the accept cycle becomes bit 1 of the next frame.
    assign take_shift = shift_en_i & ((state_q == StLoad) | accept);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StLoad;
            ops_q     <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (take_shift) begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    // Shift-left form also covers SRC_WIDTH == 1.
                    ops_q[i*SRC_WIDTH +: SRC_WIDTH] <=
                        {ops_q[i*SRC_WIDTH +: SRC_WIDTH] << 1} | SRC_WIDTH'(src_in_i[i]);
                end
                if (bit_cnt_q == LastCnt) begin
                    bit_cnt_q <= '0;
                    state_q   <= StFull;
                    valid_q   <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    state_q   <= StLoad;
                    valid_q   <= 1'b0;
                end
            end else if (accept) begin
                state_q <= StLoad;
                valid_q <= 1'b0;
            end

            if ((state_q == StFull) && shift_en_i && !accept) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign ops_out_o   = ops_q;
    assign ops_valid_o = valid_q;
    assign bit_cnt_o   = bit_cnt_q;
    assign overrun_o   = overrun_q;

`ifdef OPERAND_SHIFT_LOADER_READBACK_EN
    logic [DST_WIDTH-1:0] dst_q;

    // Accept reloads the result even if the previous readback is unfinished.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dst_q <= '0;
        end else if (accept) begin
            dst_q <= dst_in_i;
        end else if (shift_en_i) begin
            dst_q <= dst_q << 1;
        end
    end

    assign dst_serial_o = dst_q[DST_WIDTH-1];
`else
    logic unused_dst;
    assign unused_dst   = ^dst_in_i;
    assign dst_serial_o = 1'b0;
`endif

endmodule

// File: tb/tb_operand_shift_loader.sv
module tb_operand_shift_loader;

    localparam int unsigned NumSrc   = 4;
    localparam int unsigned SrcWidth = 8;
    localparam int unsigned DstWidth = 36;

    logic                         clk;
    logic                         rst;
    logic                         shift_en;
    logic [NumSrc-1:0]            src_in;
    logic [NumSrc*SrcWidth-1:0]   ops_out;
    logic                         ops_valid;
    logic                         ops_ready;
    logic [3:0]                   bit_cnt;
    logic                         overrun;
    logic [DstWidth-1:0]          dst_in;
    logic                         dst_serial;

    operand_shift_loader #(
        .NUM_SRC   (NumSrc),
        .SRC_WIDTH (SrcWidth),
        .DST_WIDTH (DstWidth)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .shift_en_i   (shift_en),
        .src_in_i     (src_in),
        .ops_out_o    (ops_out),
        .ops_valid_o  (ops_valid),
        .ops_ready_i  (ops_ready),
        .bit_cnt_o    (bit_cnt),
        .overrun_o    (overrun),
        .dst_in_i     (dst_in),
        .dst_serial_o (dst_serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];
    int          acc_t[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted frame is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ops_valid && ops_ready) begin
            acc_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_unexpected: got %0h expected none", ops_out);
            end else begin
                check("frame", 64'(ops_out), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift one 4-channel frame MSB first; frame = {ch3, ch2, ch1, ch0}.
    task automatic shift_frame(input logic [31:0] frame);
        for (int k = 0; k < 8; k++) begin
            shift_en = 1'b1;
            for (int i = 0; i < 4; i++) src_in[i] = frame[i*8 + 7 - k];
            tick();
        end
        shift_en = 1'b0;
    endtask

    initial begin
        logic [31:0] frames [3];
        logic [35:0] dst_const;
        int          acc_base;

        frames[0] = 32'h44332211;
        frames[1] = 32'hDEADBEEF;
        frames[2] = 32'h0F1E2D3C;
        dst_const = 36'h8_0000_0001;

        rst       = 1'b1;
        shift_en  = 1'b0;
        src_in    = '0;
        ops_ready = 1'b0;
        dst_in    = dst_const;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_ops", 64'(ops_out), 64'h0);
        check("reset_valid", 64'(ops_valid), 64'h0);
        check("reset_cnt", 64'(bit_cnt), 64'h0);
        check("reset_overrun", 64'(overrun), 64'h0);
        check("reset_dst_serial", 64'(dst_serial), 64'h0);

        // First frame, held with ready low
        exp_q.push_back(32'h3CFF00A5);
        shift_frame(32'h3CFF00A5);
        check("frame1_valid", 64'(ops_valid), 64'h1);
        check("frame1_cnt", 64'(bit_cnt), 64'h0);
        check("frame1_ops", 64'(ops_out), 64'h3CFF00A5);

        // Shifts while held are ignored and flag overrun
        shift_en = 1'b1;
        src_in   = 4'hF;
        repeat (3) tick();
        shift_en = 1'b0;
        check("held_ops", 64'(ops_out), 64'h3CFF00A5);
        check("held_cnt", 64'(bit_cnt), 64'h0);
        check("held_overrun", 64'(overrun), 64'h1);
        check("held_valid", 64'(ops_valid), 64'h1);
        ops_ready = 1'b1;
        tick();
        ops_ready = 1'b0;
        check("accept_valid_low", 64'(ops_valid), 64'h0);
        check("overrun_sticky", 64'(overrun), 64'h1);

        // Back-to-back frames with ready tied high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'h0);
        ops_ready = 1'b1;
        acc_base  = acc_t.size();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(frames[f]);
            shift_frame(frames[f]);
            shift_en = 1'b0;
        end
        // Note: shift_frame drops shift_en only after its last tick, so the
        // 24 shift cycles are contiguous except for that same-time reassert.
        tick();
        check("b2b_accepts", 64'(acc_t.size() - acc_base), 64'd3);
        if (acc_t.size() - acc_base == 3) begin
            check("b2b_gap1", 64'(acc_t[acc_base+1] - acc_t[acc_base]), 64'd8);
            check("b2b_gap2", 64'(acc_t[acc_base+2] - acc_t[acc_base+1]), 64'd8);
        end
        check("b2b_overrun", 64'(overrun), 64'h0);
        check("b2b_cnt", 64'(bit_cnt), 64'h0);
        check("b2b_valid", 64'(ops_valid), 64'h0);
        ops_ready = 1'b0;

        // Reset mid-frame discards partial data
        shift_en = 1'b1;
        src_in   = 4'hF;
        repeat (5) tick();
        check("partial_cnt", 64'(bit_cnt), 64'd5);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        shift_en = 1'b0;
        check("midrst_cnt", 64'(bit_cnt), 64'h0);
        check("midrst_ops", 64'(ops_out), 64'h0);
        check("midrst_valid", 64'(ops_valid), 64'h0);
        exp_q.push_back(32'hF00F8001);
        shift_frame(32'hF00F8001);
        check("clean_valid", 64'(ops_valid), 64'h1);
        check("clean_ops", 64'(ops_out), 64'hF00F8001);

        // Accept and shift in the same cycle: shift starts the next frame
        ops_ready = 1'b1;
        shift_en  = 1'b1;
        src_in    = 4'b0101;
        tick();
        ops_ready = 1'b0;
        shift_en  = 1'b0;
        check("acc_shift_valid", 64'(ops_valid), 64'h0);
        check("acc_shift_cnt", 64'(bit_cnt), 64'h1);
        check("acc_shift_overrun", 64'(overrun), 64'h0);
        check("acc_shift_ops", 64'(ops_out), 64'hE01F0003);

`ifdef OPERAND_SHIFT_LOADER_READBACK_EN
        // Result captured at the last accept comes back MSB first
        src_in = '0;
        for (int k = 0; k < 36; k++) begin
            shift_en = 1'b1;
            check($sformatf("dst_bit%0d", 35 - k), 64'(dst_serial), 64'(dst_const[35-k]));
            tick();
        end
        shift_en = 1'b0;
`else
        shift_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("dst_tied_low", 64'(dst_serial), 64'h0);
            tick();
        end
        shift_en = 1'b0;
`endif

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
